// File: rtl/clk_div_multi.sv
// clk_div_multi: NCH runtime-programmable 50%-duty clock dividers with rise strobes.
// Optional feature macro: CLKDIV_PHASE_ALIGN_EN (Sync realigns all enabled channels).
`default_nettype none

module clk_div_multi #(
  parameter int NCH     = 4,
  parameter int CNT_W   = 26,
  parameter int DEF_DIV = 10000,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [NCH-1:0]   En,
  input  logic             CfgWe,
  input  logic [CH_W-1:0]  CfgCh,
  input  logic [CNT_W-1:0] CfgDiv,
  input  logic             Sync,
  output logic [NCH-1:0]   ClkOut,
  output logic [NCH-1:0]   Tick,
  output logic [NCH-1:0]   Pend
);

`ifndef CLKDIV_PHASE_ALIGN_EN
  logic unused_sync;
  assign unused_sync = Sync;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] shd;
    logic             pend;
    logic             clk_q;
    logic             tick_q;
    logic             active;
    logic             at_top;
    logic             wr;
    logic             sync_hit;

    // A channel keeps counting while high even with En low, so a high phase is never cut short.
    assign active = En[i] | clk_q;
    assign at_top = (cnt == div);
    assign wr     = CfgWe && (CfgCh == CH_W'(i));

`ifdef CLKDIV_PHASE_ALIGN_EN
    assign sync_hit = Sync & En[i];
`else
    assign sync_hit = 1'b0;
`endif

    always_ff @(posedge Clk) begin
      if (Rst) begin
        cnt    <= '0;
        div    <= CNT_W'(DEF_DIV);
        shd    <= CNT_W'(DEF_DIV);
        pend   <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        tick_q <= 1'b0;
        if (sync_hit) begin
          cnt   <= '0;
          clk_q <= 1'b0;
          if (pend) begin
            div  <= shd;
            pend <= 1'b0;
          end
        end else if (active) begin
          if (at_top) begin
            cnt    <= '0;
            clk_q  <= ~clk_q;
            tick_q <= ~clk_q;
            if (pend) begin
              div  <= shd;
              pend <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end else begin
          cnt <= '0;
          if (pend) begin
            div  <= shd;
            pend <= 1'b0;
          end
        end
        // Placed last so a write landing on an applying toggle stays pending for the next one.
        if (wr) begin
          shd  <= CfgDiv;
          pend <= 1'b1;
        end
      end
    end

    assign ClkOut[i] = clk_q;
    assign Tick[i]   = tick_q;
    assign Pend[i]   = pend;
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: randomized and directed stimulus against an event-time model.
`default_nettype none

module tb_clk_div_multi;
  localparam int NCH     = 4;
  localparam int CNT_W   = 8;
  localparam int DEF_DIV = 3;

  logic             Clk = 1'b0;
  logic             Rst;
  logic [NCH-1:0]   En;
  logic             CfgWe;
  logic [1:0]       CfgCh;
  logic [CNT_W-1:0] CfgDiv;
  logic             Sync;
  logic [NCH-1:0]   ClkOut;
  logic [NCH-1:0]   Tick;
  logic [NCH-1:0]   Pend;

  clk_div_multi #(.NCH(NCH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .CfgWe(CfgWe), .CfgCh(CfgCh),
    .CfgDiv(CfgDiv), .Sync(Sync), .ClkOut(ClkOut), .Tick(Tick), .Pend(Pend)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [NCH-1:0] c;
    logic [NCH-1:0] t;
    logic [NCH-1:0] p;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Model: each channel schedules its next toggle as an absolute cycle number.
  bit     m_lvl[NCH];
  bit     m_tk[NCH];
  bit     m_pd[NCH];
  bit     m_run[NCH];
  int     m_div[NCH];
  int     m_shd[NCH];
  longint m_nxt[NCH];
  longint cyc = 0;
  bit [NCH-1:0] en_s = '0;

  task automatic step(input bit rst, input bit we, input int ch, input int d, input bit sync);
    exp_t e;
    Rst    = rst;
    En     = en_s;
    CfgWe  = we;
    CfgCh  = ch[1:0];
    CfgDiv = d[CNT_W-1:0];
    Sync   = sync;
    for (int i = 0; i < NCH; i++) begin
      if (rst) begin
        m_lvl[i] = 0; m_tk[i] = 0; m_pd[i] = 0; m_run[i] = 0;
        m_div[i] = DEF_DIV; m_shd[i] = DEF_DIV; m_nxt[i] = 0;
      end else begin
        bit synced = 0;
        m_tk[i] = 0;
`ifdef CLKDIV_PHASE_ALIGN_EN
        if (sync && en_s[i]) begin
          synced   = 1;
          m_lvl[i] = 0;
          if (m_pd[i]) begin m_div[i] = m_shd[i]; m_pd[i] = 0; end
          m_run[i] = 1;
          m_nxt[i] = cyc + 1 + m_div[i];
        end
`endif
        if (!synced) begin
          if (en_s[i] || m_lvl[i]) begin
            if (!m_run[i]) begin
              m_run[i] = 1;
              m_nxt[i] = cyc + m_div[i];
            end
            if (cyc == m_nxt[i]) begin
              m_lvl[i] = !m_lvl[i];
              m_tk[i]  = m_lvl[i];
              if (m_pd[i]) begin m_div[i] = m_shd[i]; m_pd[i] = 0; end
              m_nxt[i] = cyc + 1 + m_div[i];
            end
          end else begin
            m_run[i] = 0;
            if (m_pd[i]) begin m_div[i] = m_shd[i]; m_pd[i] = 0; end
          end
        end
        if (we && ch == i) begin
          m_shd[i] = d;
          m_pd[i]  = 1;
        end
      end
      e.c[i] = m_lvl[i];
      e.t[i] = m_tk[i];
      e.p[i] = m_pd[i];
    end
    exp_q.push_back(e);
    cyc++;
    @(negedge Clk);
  endtask

  task automatic idle_n(input int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string nm, input logic [NCH-1:0] act, input logic [NCH-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at t=%0t: actual=%b required=%b", nm, $time, act, req);
    end
  endtask

  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ClkOut", ClkOut, e.c);
      chk("Tick", Tick, e.t);
      chk("Pend", Pend, e.p);
    end
  end

  initial begin
    int r;
    // Reset state
    en_s = '0;
    repeat (3) step(1, 0, 0, 0, 0);

    // Channel 0 at the reset divisor: rise after 4 cycles, period 8
    en_s = 4'b0001;
    idle_n(20);

    // Reprogram ch0 to 1 during a high phase
    for (int k = 0; k < 20 && !m_lvl[0]; k++) idle_n(1);
    idle_n(1);
    step(0, 1, 0, 1, 0);
    idle_n(16);

    // ch1 at D=0, then drop its enable while high
    step(0, 1, 1, 0, 0);
    en_s[1] = 1'b1;
    idle_n(6);
    for (int k = 0; k < 4 && !m_lvl[1]; k++) idle_n(1);
    en_s[1] = 1'b0;
    idle_n(4);

    // Two writes to ch2 before its toggle: last one wins
    en_s[2] = 1'b1;
    idle_n(1);
    step(0, 1, 2, 5, 0);
    step(0, 1, 2, 7, 0);
    idle_n(40);

    // Reset mid-count with every channel running
    en_s = 4'b1111;
    idle_n(7);
    step(1, 0, 0, 0, 0);
    idle_n(12);

    // ch0/ch1 out of phase at D=2, then a Sync pulse
    en_s = '0;
    for (int k = 0; k < 40 && (m_lvl[0] || m_lvl[1] || m_lvl[2] || m_lvl[3]); k++) idle_n(1);
    step(0, 1, 0, 2, 0);
    step(0, 1, 1, 2, 0);
    en_s = 4'b0001;
    idle_n(2);
    en_s = 4'b0011;
    idle_n(8);
    step(0, 0, 0, 0, 1);
    idle_n(10);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      bit we, sy, rs;
      if ($urandom_range(19) == 0) begin
        r = $urandom_range(NCH - 1);
        en_s[r] = !en_s[r];
      end
      we = ($urandom_range(5) == 0);
      sy = ($urandom_range(29) == 0);
      rs = ($urandom_range(299) == 0);
      step(rs, we, $urandom_range(NCH - 1), $urandom_range(6), sy);
    end

    idle_n(2);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: actual=%0d required=0 outstanding", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clk_div_multi.md
# clk_div_multi

Multi-channel, runtime-programmable clock divider. It replaces the fixed-ratio single-output divider in the board top level. Each of `NCH` channels produces a 50 %-duty divided clock (`ClkOut`) and a one-cycle enable strobe (`Tick`) from the 100 MHz board clock. Divisors are written over a simple config port and take effect glitch-free at a half-period boundary. Typical consumers are the slow display/LED clocks and the per-core step clocks.

## Interface
- `NCH`, default 4: number of independent channels (1..16).
- `CNT_W`, default 26: counter and divisor width.
- `DEF_DIV`, default 10000: divisor loaded into every channel at reset. Must fit in `CNT_W`.
- `Clk`, in, 1: system clock.
- `Rst`, in, 1: reset. Synchronous, active-high; clock `Clk`.
- `En`, in, `NCH`: per-channel run enable.
- `CfgWe`, in, 1: divisor write strobe; one write per asserted cycle.
- `CfgCh`, in, `$clog2(NCH)` (min 1): target channel.
- `CfgDiv`, in, `CNT_W`: new divisor value `D`.
- `Sync`, in, 1: phase-align request. Only active with `CLKDIV_PHASE_ALIGN_EN`.
- `ClkOut`, out, `NCH`: divided clocks. Period is 2·(D+1) `Clk` cycles.
- `Tick`, out, `NCH`: one-`Clk` pulse in the cycle `ClkOut[i]` goes 0→1.
- `Pend`, out, `NCH`: a written divisor is waiting to be applied.

## Operation
- Per channel state: counter `Cnt` (`CNT_W` bits), active divisor `Div`, shadow `Shd`, pending flag, and phase bit `ClkOut[i]`.
- Channel states:
  - IDLE: `En=0` and `ClkOut=0`. `Cnt` is held at 0.
  - RUN: `En=1`.
  - DRAIN: `En=0` and `ClkOut=1`. The channel keeps counting until the falling toggle, then enters IDLE. `ClkOut` is never truncated to a runt high pulse.
- RUN/DRAIN behaviour each cycle:
  - If `Cnt==Div`: toggle `ClkOut`, set `Cnt←0`. If pending, load `Div←Shd` and clear pending in that same cycle.
  - Otherwise: `Cnt←Cnt+1`.
- IDLE→RUN: the first toggle (0→1) occurs when `Cnt` reaches `Div`, i.e. D+1 cycles after `En` is first seen high.
- Config writes:
  - `CfgWe=1` sets `Shd[CfgCh]←CfgDiv` and `Pend[CfgCh]←1`.
  - A second write before application overwrites `Shd`; last write wins.
  - In IDLE, a pending divisor is applied immediately on the next cycle.
  - Out-of-range `CfgCh` (≥`NCH`) is ignored.
- Write on the exact cycle the channel toggles with `Cnt==Div`:
  - The old pending value, if any, is applied at this toggle.
  - The new write becomes pending for the next toggle.
- `D=0`: `ClkOut` toggles every cycle, giving `Clk`/2.
- Comparison is `Cnt==Div`, never `>=`. `Div` only changes at a toggle, when `Cnt` is 0, so the counter cannot overrun.
- Reset mid-operation: all state returns to reset values the next cycle, regardless of phase.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset values:
  - `ClkOut=0`, `Tick=0`, `Pend=0`
  - `Cnt=0`, `Div=Shd=DEF_DIV`
- `Tick[i]` is high in the same cycle `ClkOut[i]` first reads 1, and for exactly one cycle.
- Write-to-pending latency: `Pend` is visible 1 cycle after `CfgWe`.
- Write-to-effect latency: at the next toggle of that channel (IDLE: 1 cycle).
- `Rst` dominates `CfgWe`, `En` and `Sync` in the same cycle.

## Configuration
- `CLKDIV_PHASE_ALIGN_EN` defined:
  - A cycle with `Sync=1` forces every channel with `En=1` to `Cnt←0`, `ClkOut←0`, `Tick←0`. Pending divisors are applied.
  - All enabled channels then share a common rising-edge origin. With equal divisors, their `Tick` pulses coincide.
  - `Sync` overrides a same-cycle toggle.
  - `Sync` concurrent with `CfgWe`: the write goes to `Shd`/pending and is not applied by this `Sync`.
- Macro undefined: `Sync` is ignored, and the synchronising logic is not synthesised.

## Test plan
- Reset, `NCH=4`, `DEF_DIV=3`, `En=4'b0001` → `ClkOut[0]` rises at cycle 4, period 8, duty 4/4, `Tick[0]` one cycle at each rise. Other channels stay 0.
- Write ch0 `D=1` mid-high-phase with `DEF_DIV=3` → `Pend[0]=1`. The current half-period completes at 4 cycles, then the period becomes 4. `Pend[0]` clears at that toggle.
- `D=0` on ch1, `En[1]=1` → `ClkOut[1]` alternates every cycle and `Tick[1]` pulses every other cycle. Deassert `En[1]` while high → exactly one more cycle high, then it holds 0.
- Two writes to ch2 (5, then 7) before its toggle → only 7 is applied, and the period becomes 16.
- Assert `Rst` with all channels running mid-count → next cycle all outputs are 0 and `Div` is back to `DEF_DIV`.
- (`CLKDIV_PHASE_ALIGN_EN`) ch0 and ch1 at `D=2` out of phase, pulse `Sync` → both rise 3 cycles later on the same cycle, with coincident `Tick`. Without the macro, the phase offset is unchanged.
